plot_arbiter: RTL and testbench

Shares the single VGA frame-buffer write port among NREQ drawing requesters, such as the game controller's erase/draw/frozen plots, the maze renderer and the win-screen painter. Each request asks for one square tile of 2^TILE_LOG2 × 2^TILE_LOG2 pixels in one colour. The block picks requesters round-robin, latches the tile coordinates and colour of the chosen one, and emits one pixel write per cycle. When the tile is finished it returns a one-cycle done pulse to that requester.

---
 rtl/plot_arbiter_pkg.sv | 19 +
 rtl/plot_arbiter_rr_arbiter.sv | 34 +++
 rtl/plot_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_plot_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_arbiter_pkg.sv
// Shared definitions for the frame-buffer plot arbiter: FSM encoding, colour codes
// and the default tile size. Optional full-screen clear is enabled by PLOT_ARBITER_CLEAR_EN.
package plot_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    DONE  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // Colour codes shared with the game controller's colour select.
  localparam logic [2:0] BLACK  = 3'd0;
  localparam logic [2:0] PLAYER = 3'd1;
  localparam logic [2:0] ICE    = 3'd2;

  localparam int DEFAULT_TILE_LOG2 = 2;

endpackage

// File: rtl/plot_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after ptr_i
// (wrapping modulo NREQ) wins.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] winner_o,
  output logic [PW-1:0]   winner_idx_o,
  output logic            any_req_o
);

  logic          found;
  logic [PW-1:0] cand;

  always_comb begin
    winner_o     = '0;
    winner_idx_o = '0;
    found        = 1'b0;
    cand         = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(ptr_i) + i) % NREQ);
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        winner_o[cand]  = 1'b1;
        winner_idx_o    = cand;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin owner of the VGA write port: latches one requester's tile and plots it
// pixel by pixel. Define PLOT_ARBITER_CLEAR_EN to add the full-screen clear sweep.
module plot_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int TILE_LOG2 = DEFAULT_TILE_LOG2,
  parameter int TXW       = 5,
  parameter int TYW       = 5,
  parameter int XW        = 8,
  parameter int YW        = 7,
  parameter int CW        = 3
`ifdef PLOT_ARBITER_CLEAR_EN
  ,
  parameter int SCR_W     = 160,
  parameter int SCR_H     = 120
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*TXW-1:0] tile_x,
  input  logic [NREQ*TYW-1:0] tile_y,
  input  logic [NREQ*CW-1:0]  color,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [XW-1:0]     vga_x,
  output logic [YW-1:0]     vga_y,
  output logic [CW-1:0]     vga_color,
  output logic              vga_plot,
  output logic              busy,
`ifdef PLOT_ARBITER_CLEAR_EN
  input  logic              clear_req,
  output logic              clear_done,
`endif
  output state_t            dbg_state
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int XCW = TXW + TILE_LOG2;
  localparam int YCW = TYW + TILE_LOG2;

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         win_idx_q, win_idx_d;
  logic [NREQ-1:0]       grant_q, grant_d;
  logic [TXW-1:0]        tx_q, tx_d;
  logic [TYW-1:0]        ty_q, ty_d;
  logic [CW-1:0]         col_q, col_d;
  logic [TILE_LOG2-1:0]  px_q, px_d;
  logic [TILE_LOG2-1:0]  py_q, py_d;
  logic                  clear_mode_q, clear_mode_d;
`ifdef PLOT_ARBITER_CLEAR_EN
  logic [XW-1:0]         cx_q, cx_d;
  logic [YW-1:0]         cy_q, cy_d;
`endif

  logic [NREQ-1:0]       arb_onehot;
  logic [PW-1:0]         arb_idx;
  logic                  arb_any;

  logic [TXW-1:0]        tx_arr [NREQ];
  logic [TYW-1:0]        ty_arr [NREQ];
  logic [CW-1:0]         col_arr [NREQ];

  logic [XCW-1:0]        x_cat;
  logic [YCW-1:0]        y_cat;
  logic [XW-1:0]         x_tile;
  logic [YW-1:0]         y_tile;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign tx_arr[g]  = tile_x[g*TXW +: TXW];
    assign ty_arr[g]  = tile_y[g*TYW +: TYW];
    assign col_arr[g] = color[g*CW +: CW];
  end

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req_i        (req),
    .ptr_i        (ptr_q),
    .winner_o     (arb_onehot),
    .winner_idx_o (arb_idx),
    .any_req_o    (arb_any)
  );

  // Pixel address is the tile coordinate with the in-tile offset appended as LSBs.
  assign x_cat = {tx_q, px_q};
  assign y_cat = {ty_q, py_q};

  if (XCW >= XW) begin : g_x_trunc
    assign x_tile = x_cat[XW-1:0];
  end else begin : g_x_ext
    assign x_tile = {{(XW-XCW){1'b0}}, x_cat};
  end

  if (YCW >= YW) begin : g_y_trunc
    assign y_tile = y_cat[YW-1:0];
  end else begin : g_y_ext
    assign y_tile = {{(YW-YCW){1'b0}}, y_cat};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      win_idx_q    <= '0;
      grant_q      <= '0;
      tx_q         <= '0;
      ty_q         <= '0;
      col_q        <= '0;
      px_q         <= '0;
      py_q         <= '0;
      clear_mode_q <= 1'b0;
`ifdef PLOT_ARBITER_CLEAR_EN
      cx_q         <= '0;
      cy_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_idx_q    <= win_idx_d;
      grant_q      <= grant_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      col_q        <= col_d;
      px_q         <= px_d;
      py_q         <= py_d;
      clear_mode_q <= clear_mode_d;
`ifdef PLOT_ARBITER_CLEAR_EN
      cx_q         <= cx_d;
      cy_q         <= cy_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_idx_d    = win_idx_q;
    grant_d      = grant_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
    col_d        = col_q;
    px_d         = px_q;
    py_d         = py_q;
    clear_mode_d = clear_mode_q;
`ifdef PLOT_ARBITER_CLEAR_EN
    cx_d         = cx_q;
    cy_d         = cy_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef PLOT_ARBITER_CLEAR_EN
        if (clear_req) begin
          state_d      = CLEAR;
          clear_mode_d = 1'b1;
          cx_d         = '0;
          cy_d         = '0;
        end else
`endif
        if (arb_any) begin
          state_d      = DRAW;
          clear_mode_d = 1'b0;
          win_idx_d    = arb_idx;
          grant_d      = arb_onehot;
          tx_d         = tx_arr[arb_idx];
          ty_d         = ty_arr[arb_idx];
          col_d        = col_arr[arb_idx];
          px_d         = '0;
          py_d         = '0;
        end
      end
      DRAW: begin
        px_d = px_q + 1'b1;
        if (px_q == '1) begin
          py_d = py_q + 1'b1;
          if (py_q == '1) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        // A clear sweep leaves the fairness pointer where it was.
        if (!clear_mode_q) begin
          ptr_d = (win_idx_q == PW'(NREQ-1)) ? '0 : win_idx_q + 1'b1;
        end
      end
`ifdef PLOT_ARBITER_CLEAR_EN
      CLEAR: begin
        cx_d = cx_q + 1'b1;
        if (cx_q == XW'(SCR_W-1)) begin
          cx_d = '0;
          cy_d = cy_q + 1'b1;
          if (cy_q == YW'(SCR_H-1)) state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant     = '0;
    done      = '0;
    vga_plot  = 1'b0;
    vga_x     = '0;
    vga_y     = '0;
    vga_color = '0;
`ifdef PLOT_ARBITER_CLEAR_EN
    clear_done = 1'b0;
`endif
    case (state_q)
      DRAW: begin
        grant     = grant_q;
        vga_plot  = 1'b1;
        vga_x     = x_tile;
        vga_y     = y_tile;
        vga_color = col_q;
      end
      DONE: begin
        if (!clear_mode_q) done = grant_q;
`ifdef PLOT_ARBITER_CLEAR_EN
        else clear_done = 1'b1;
`endif
      end
`ifdef PLOT_ARBITER_CLEAR_EN
      CLEAR: begin
        vga_plot  = 1'b1;
        vga_x     = cx_q;
        vga_y     = cy_q;
        vga_color = CW'(BLACK);
      end
`endif
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: directed tiles push expected pixels and done pulses;
// a negedge monitor pops and compares. Covers PLOT_ARBITER_CLEAR_EN when defined.
`timescale 1ns/1ps
module tb_plot_arbiter;
  import plot_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int TXW  = 5;
  localparam int TYW  = 5;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CW   = 3;
  localparam int TILE = 4;
  localparam int EW   = XW + YW + CW + NREQ;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*TXW-1:0] tile_x;
  logic [NREQ*TYW-1:0] tile_y;
  logic [NREQ*CW-1:0]  color;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     done;
  logic [XW-1:0]       vga_x;
  logic [YW-1:0]       vga_y;
  logic [CW-1:0]       vga_color;
  logic                vga_plot;
  logic                busy;
  state_t              dbg_state;
`ifdef PLOT_ARBITER_CLEAR_EN
  logic                clear_req;
  logic                clear_done;
`endif

  plot_arbiter #(
    .NREQ(NREQ), .TILE_LOG2(2), .TXW(TXW), .TYW(TYW), .XW(XW), .YW(YW), .CW(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .color      (color),
    .grant      (grant),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_color  (vga_color),
    .vga_plot   (vga_plot),
    .busy       (busy),
`ifdef PLOT_ARBITER_CLEAR_EN
    .clear_req  (clear_req),
    .clear_done (clear_done),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int              n_cmp = 0;
  int              n_err = 0;
  logic [EW-1:0]   exp_q[$];
  logic [NREQ-1:0] done_q[$];
  int              gaps_q[$];
  bit              mon_seen = 1'b0;
  bit              prev_plot = 1'b0;
  int              idle_run = 0;
  logic [EW-1:0]   exp_e;
  logic [NREQ-1:0] exp_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] need);
    n_cmp++;
    if (act !== need) begin
      n_err++;
      $display("FAIL %s: got %0d, need %0d", name, act, need);
    end
  endtask

  task automatic set_tile(input int idx, input int tx, input int ty, input int col);
    tile_x[idx*TXW +: TXW] = TXW'(tx);
    tile_y[idx*TYW +: TYW] = TYW'(ty);
    color[idx*CW +: CW]    = CW'(col);
  endtask

  // Expected pixels of a tile in row-major order; npix < 16 models an aborted tile.
  task automatic push_tile(input int idx, input int tx, input int ty, input int col,
                           input int npix, input bit with_done);
    int n;
    n = 0;
    for (int py = 0; py < TILE; py++) begin
      for (int px = 0; px < TILE; px++) begin
        if (n < npix) begin
          exp_q.push_back({XW'((tx*TILE + px) % 256), YW'((ty*TILE + py) % 128),
                           CW'(col), NREQ'(1 << idx)});
        end
        n++;
      end
    end
    if (with_done) done_q.push_back(NREQ'(1 << idx));
  endtask

  task automatic wait_done(input logic [NREQ-1:0] mask, input string name, input int limit);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < limit && !hit; c++) begin
      @(negedge clk);
      if ((done & mask) != '0) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL %s: got no done pulse in %0d cycles, need done=%b", name, limit, mask);
    end
  endtask

  task automatic wait_plots(input int count, input string name);
    int k;
    k = 0;
    for (int c = 0; c < 60 && k < count; c++) begin
      @(negedge clk);
      if (vga_plot) k++;
    end
    check(name, k, count);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (vga_plot) begin
      if (!prev_plot && mon_seen) gaps_q.push_back(idle_run);
      mon_seen = 1'b1;
      idle_run = 0;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_plot: got x=%0d y=%0d c=%0d g=%b, need no write",
                 vga_x, vga_y, vga_color, grant);
      end else begin
        exp_e = exp_q.pop_front();
        if ({vga_x, vga_y, vga_color, grant} !== exp_e) begin
          n_err++;
          $display("FAIL pixel: got x=%0d y=%0d c=%0d g=%b, need x=%0d y=%0d c=%0d g=%b",
                   vga_x, vga_y, vga_color, grant,
                   exp_e[EW-1 -: XW], exp_e[EW-XW-1 -: YW], exp_e[NREQ +: CW],
                   exp_e[NREQ-1:0]);
        end
      end
    end else begin
      idle_run++;
    end
    prev_plot = vga_plot;
    if (done != '0) begin
      n_cmp++;
      if (done_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_done: got done=%b, need none", done);
      end else begin
        exp_d = done_q.pop_front();
        if (done !== exp_d) begin
          n_err++;
          $display("FAIL done_order: got done=%b, need done=%b", done, exp_d);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by 500us, need completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b1;
    req    = '0;
    tile_x = '0;
    tile_y = '0;
    color  = '0;
`ifdef PLOT_ARBITER_CLEAR_EN
    clear_req = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_busy", busy, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_color", vga_color, 0);
    check("rst_state", dbg_state, IDLE);
    reset = 1'b0;

    // Single request: tile (3,2) colour PLAYER.
    set_tile(0, 3, 2, PLAYER);
    push_tile(0, 3, 2, PLAYER, 16, 1'b1);
    req = 3'b001;
    @(negedge clk);
    check("t1_latency_plot", vga_plot, 1);
    wait_done(3'b001, "t1_done", 40);
    req = '0;
    @(negedge clk);
    check("t1_busy_after", busy, 0);
    check("t1_grant_after", grant, 0);
    @(negedge clk);
    check("t1_still_idle", busy, 0);

    // Two held requests from pointer 0: order 0,1,0,1 with 2-cycle gaps.
    pulse_reset();
    set_tile(0, 1, 1, ICE);
    set_tile(1, 2, 3, 3);
    push_tile(0, 1, 1, ICE, 16, 1'b1);
    push_tile(1, 2, 3, 3, 16, 1'b1);
    push_tile(0, 1, 1, ICE, 16, 1'b1);
    push_tile(1, 2, 3, 3, 16, 1'b1);
    mon_seen = 1'b0;
    gaps_q.delete();
    req = 3'b011;
    wait_done(3'b001, "t2_done_a", 40);
    wait_done(3'b010, "t2_done_b", 40);
    wait_done(3'b001, "t2_done_c", 40);
    wait_done(3'b010, "t2_done_d", 40);
    req = '0;
    repeat (2) @(negedge clk);
    check("t2_gap_count", gaps_q.size(), 3);
    foreach (gaps_q[i]) check("t2_gap_len", gaps_q[i], 2);

    // Requester 2 drops req and changes its inputs mid-tile.
    set_tile(2, 5, 6, ICE);
    push_tile(2, 5, 6, ICE, 16, 1'b1);
    req = 3'b100;
    wait_plots(5, "t3_plots");
    req = '0;
    set_tile(2, 9, 1, 5);
    wait_done(3'b100, "t3_done", 40);
    @(negedge clk);
    check("t3_busy_after", busy, 0);

    // Boundary tile (31,31).
    set_tile(0, 31, 31, 7);
    push_tile(0, 31, 31, 7, 16, 1'b1);
    req = 3'b001;
    wait_done(3'b001, "t4_done", 40);
    req = '0;
    repeat (3) @(negedge clk);
    check("t4_busy_after", busy, 0);

    // Reset at plot cycle 8 aborts the tile; pointer restarts at 0.
    set_tile(1, 4, 4, PLAYER);
    push_tile(1, 4, 4, PLAYER, 8, 1'b0);
    req = 3'b010;
    wait_plots(8, "t5_plots");
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    check("t5_plot_after_rst", vga_plot, 0);
    check("t5_grant_after_rst", grant, 0);
    check("t5_done_after_rst", done, 0);
    check("t5_state_after_rst", dbg_state, IDLE);
    reset = 1'b0;
    set_tile(0, 1, 2, 3);
    set_tile(2, 6, 7, 4);
    push_tile(0, 1, 2, 3, 16, 1'b1);
    push_tile(2, 6, 7, 4, 16, 1'b1);
    req = 3'b101;
    wait_done(3'b001, "t5_done_0", 40);
    req = 3'b100;
    wait_done(3'b100, "t5_done_2", 40);
    req = '0;
    repeat (3) @(negedge clk);

`ifdef PLOT_ARBITER_CLEAR_EN
    begin : clear_test
      bit hit;
      for (int y = 0; y < 120; y++)
        for (int x = 0; x < 160; x++)
          exp_q.push_back({XW'(x), YW'(y), CW'(0), NREQ'(0)});
      set_tile(0, 2, 2, PLAYER);
      push_tile(0, 2, 2, PLAYER, 16, 1'b1);
      clear_req = 1'b1;
      req       = 3'b001;
      wait_plots(1, "clr_start");
      clear_req = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 20000 && !hit; c++) begin
        @(negedge clk);
        if (clear_done) hit = 1'b1;
      end
      check("clr_done_seen", hit, 1);
      check("clr_busy_in_done", busy, 1);
      wait_done(3'b001, "clr_then_req0", 40);
      req = '0;
      repeat (3) @(negedge clk);
    end
`endif

    check("exp_pixels_left", exp_q.size(), 0);
    check("exp_done_left", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
